fabric_config_loader: RTL and testbench

Top-level sequencer for fabric configuration. On a `load` request it drives an attached bitstream reader once per tile, NUM_TILES times, and writes each captured TILE_BITS word into the fabric configuration store. It then reads one trailing checksum word and compares it against the running XOR of all tile words. It sits between the bitstream reader and the tile configuration registers, and gates the fabric enable until a load completes cleanly.

---
 rtl/fabric_config_loader.sv | 197 +++++++++++++++++++
 tb/tb_fabric_config_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_loader.sv
// fabric_config_loader
//
// Sequences one fabric configuration load. Each load runs in three phases:
//   1. For every tile, fetch one word from the bitstream reader.
//   2. Write that word into the configuration store.
//   3. Fetch one trailing checksum word and compare it with the XOR of all
//      tile words.
// The fabric enable is held off until a load completes with a matching
// checksum.
//
// Ports
//   clk, rst_n         : rising-edge clock; synchronous active-low reset
//   load               : one-cycle request to start a load (ignored while busy)
//   reader_start       : one-cycle start pulse to the bitstream reader
//   reader_ready       : one-cycle completion pulse from the reader
//   reader_bits        : reader word, qualified by reader_ready
//   cfg_we/addr/data   : configuration store write port
//   busy               : load in progress (acceptance through DONE/ERROR)
//   done, error        : sticky status, cleared when the next load is accepted
//   fabric_en          : high only after a clean load
//   dbg_state          : current FSM state, for observation only
//
// Reader handshake: reader_start is a single-cycle pulse, emitted while the
// FSM sits in ISSUE or CHECK_ISSUE. The reader answers with a single-cycle
// reader_ready, and reader_bits is valid in that same cycle. reader_ready is
// only honoured in WAIT/CHECK_WAIT; at any other time it is dropped. There is
// no back-pressure: one start produces at most one ready.
module fabric_config_loader #(
  parameter int NUM_TILES      = 4,
  parameter int TILE_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ADDR_W        = (NUM_TILES <= 2) ? 1 : $clog2(NUM_TILES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  output logic                 reader_start,
  input  logic                 reader_ready,
  input  logic [TILE_BITS-1:0] reader_bits,
  output logic                 cfg_we,
  output logic [ADDR_W-1:0]    cfg_addr,
  output logic [TILE_BITS-1:0] cfg_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 fabric_en,
  output logic [2:0]           dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] TILE_LAST = ADDR_W'(NUM_TILES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_CHECK_ISSUE,
    S_CHECK_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                 state_q,     state_d;
  logic [ADDR_W-1:0]      tile_idx_q,  tile_idx_d;
  logic [TILE_BITS-1:0]   xor_acc_q,   xor_acc_d;
  logic [TILE_BITS-1:0]   cfg_data_q,  cfg_data_d;
  logic [TO_W-1:0]        timeout_q,   timeout_d;
  logic                   busy_q,      busy_d;
  logic                   done_q,      done_d;
  logic                   error_q,     error_d;
  logic                   fabric_en_q, fabric_en_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tile_idx_q  <= '0;
      xor_acc_q   <= '0;
      cfg_data_q  <= '0;
      timeout_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      fabric_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_idx_q  <= tile_idx_d;
      xor_acc_q   <= xor_acc_d;
      cfg_data_q  <= cfg_data_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      fabric_en_q <= fabric_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tile_idx_d  = tile_idx_q;
    xor_acc_d   = xor_acc_q;
    cfg_data_d  = cfg_data_q;
    timeout_d   = timeout_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    fabric_en_d = fabric_en_q;

    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d     = S_ISSUE;
          tile_idx_d  = '0;
          xor_acc_d   = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          fabric_en_d = 1'b0;
        end
      end

      S_ISSUE: begin
        state_d   = S_WAIT;
        timeout_d = '0;
      end

      // The wait lasts at most TIMEOUT_CYCLES cycles: the counter starts at
      // zero on entry and the FSM gives up in the cycle it reads TO_LAST.
      S_WAIT: begin
        if (reader_ready) begin
          cfg_data_d = reader_bits;
          xor_acc_d  = xor_acc_q ^ reader_bits;
          state_d    = S_WRITE;
        end else if (timeout_q == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      S_WRITE: begin
        if (tile_idx_q == TILE_LAST) begin
          state_d = S_CHECK_ISSUE;
        end else begin
          tile_idx_d = tile_idx_q + ADDR_W'(1);
          state_d    = S_ISSUE;
        end
      end

      S_CHECK_ISSUE: begin
        state_d   = S_CHECK_WAIT;
        timeout_d = '0;
      end

      S_CHECK_WAIT: begin
        if (reader_ready) begin
          state_d = (reader_bits == xor_acc_q) ? S_DONE : S_ERROR;
        end else if (timeout_q == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      // Status flags change on leaving DONE/ERROR, so busy stays high for
      // the whole of these states and a load arriving here is still ignored.
      S_DONE: begin
        done_d      = 1'b1;
        fabric_en_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      S_ERROR: begin
        error_d     = 1'b1;
        fabric_en_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Every output is either a flop or a decode of the state register.
  assign reader_start = (state_q == S_ISSUE) || (state_q == S_CHECK_ISSUE);
  assign cfg_we       = (state_q == S_WRITE);
  assign cfg_addr     = tile_idx_q;
  assign cfg_data     = cfg_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign fabric_en    = fabric_en_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
module tb_fabric_config_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  // Four-tile instance.
  logic       load;
  logic       reader_start;
  logic       reader_ready;
  logic [7:0] reader_bits;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       busy, done, error, fabric_en;
  logic [2:0] dbg_state;

  // Single-tile instance.
  logic       load1;
  logic       rs1;
  logic       rr1;
  logic [7:0] rb1;
  logic       we1;
  logic [0:0] addr1;
  logic [7:0] data1;
  logic       busy1, done1, err1, fen1;
  logic [2:0] st1;

  fabric_config_loader #(.NUM_TILES(4), .TILE_BITS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .reader_start(reader_start), .reader_ready(reader_ready), .reader_bits(reader_bits),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .fabric_en(fabric_en),
    .dbg_state(dbg_state)
  );

  fabric_config_loader #(.NUM_TILES(1), .TILE_BITS(8), .TIMEOUT_CYCLES(16)) dut_one (
    .clk(clk), .rst_n(rst_n), .load(load1),
    .reader_start(rs1), .reader_ready(rr1), .reader_bits(rb1),
    .cfg_we(we1), .cfg_addr(addr1), .cfg_data(data1),
    .busy(busy1), .done(done1), .error(err1), .fabric_en(fen1),
    .dbg_state(st1)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reader model + scoreboard ----------------
  logic [7:0] rd_words[$];      // words the reader will hand out, in order
  int         rd_max_lat = 0;   // extra cycles before ready, random 0..max
  bit         rd_armed   = 0;
  int         rd_wait    = 0;
  bit         spurious_req = 0;

  logic [9:0] exp_q[$];         // expected {addr, data} writes
  int         n_starts   = 0;
  int         n_writes   = 0;
  int         n_writes1  = 0;

  // Reader: answers each start with the next queued word after a random
  // delay; with an empty queue it never answers (models a stalled reader).
  initial begin : reader_model
    reader_ready = 1'b0;
    reader_bits  = 8'h00;
    forever begin
      tick();
      reader_ready = 1'b0;
      if (rd_armed) begin
        if (rd_wait == 0) begin
          reader_ready = 1'b1;
          reader_bits  = rd_words.pop_front();
          rd_armed     = 0;
        end else begin
          rd_wait--;
        end
      end else if (spurious_req) begin
        reader_ready = 1'b1;
        reader_bits  = 8'($urandom_range(0, 255));
        spurious_req = 0;
      end
      if (reader_start && rd_words.size() > 0) begin
        rd_armed = 1;
        rd_wait  = $urandom_range(rd_max_lat, 0);
      end
    end
  end

  initial begin : monitor
    forever begin
      tick();
      if (reader_start) n_starts++;
      if (we1) n_writes1++;
      if (cfg_we) begin
        n_writes++;
        if (exp_q.size() == 0)
          check("write_unexpected", {22'd0, cfg_addr, cfg_data}, 32'hFFFF_FFFF);
        else
          check("write_addr_data", {22'd0, cfg_addr, cfg_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] words[4];

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (busy && cycles < limit) begin
      tick();
      cycles++;
    end
    if (busy) check({tag, "_idle_timeout"}, busy, 0);
  endtask

  // One load on the 4-tile instance. The reader is given the first
  // `supply` tile words (4 means all of them) and, when supply > 4, the
  // checksum as well. Expected writes and outcome come from the words alone.
  task automatic run_load(input string tag, input logic [7:0] cs, input int supply,
                          input int max_lat, output int cyc);
    logic [7:0] x;
    bit         good;
    int         s0, w0, exp_starts;
    x = 8'h00;
    for (int i = 0; i < 4; i++) x ^= words[i];
    good = (supply > 4) && (cs == x);
    exp_starts = (supply > 4) ? 5 : supply + 1;
    rd_max_lat = max_lat;
    rd_words.delete();
    for (int i = 0; i < supply && i < 4; i++) begin
      rd_words.push_back(words[i]);
      exp_q.push_back({2'(i), words[i]});
    end
    if (supply > 4) rd_words.push_back(cs);
    s0 = n_starts;
    w0 = n_writes;
    pulse_load();
    check({tag, "_busy_set"}, busy, 1);
    check({tag, "_start_pulse"}, reader_start, 1);
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_fen_clr"}, fabric_en, 0);
    wait_idle(tag, 400, cyc);
    tick();
    tick();
    check({tag, "_done"}, done, good);
    check({tag, "_error"}, error, !good);
    check({tag, "_fabric_en"}, fabric_en, good);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_writes_missing"}, exp_q.size(), 0);
    check({tag, "_write_count"}, n_writes - w0, (supply < 4) ? supply : 4);
    check({tag, "_start_count"}, n_starts - s0, exp_starts);
  endtask

  task automatic one_wait_start(input string tag);
    int n;
    n = 0;
    while (!rs1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, rs1, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin : stimulus
    int cyc, s0, w0;
    logic [7:0] x;

    rst_n = 1'b0;
    load  = 1'b0;
    load1 = 1'b0;
    rr1   = 1'b0;
    rb1   = 8'h00;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_fabric_en", fabric_en, 0);
    check("rst_reader_start", reader_start, 0);
    check("rst_cfg_we", cfg_we, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    check("rst_cfg_data", cfg_data, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Nominal load, zero-latency reader: also checks minimum latency.
    words = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load("nominal", 8'h08, 5, 0, cyc);
    check("nominal_latency", cyc, 3 * 4 + 2 + 1);

    // Bad checksum: all four writes happen, then error.
    run_load("bad_cs", 8'h09, 5, 0, cyc);

    // Reader stalls after the second start: one write, then timeout error.
    // The stalled wait lasts TIMEOUT_CYCLES cycles, give or take the
    // counter's exit cycle.
    run_load("stall", 8'h08, 1, 0, cyc);
    check("stall_length", (cyc >= 20 && cyc <= 21), 1);

    // load pulsed in WAIT of tile 1 and again in DONE must be ignored.
    words = '{8'h3C, 8'hC3, 8'h0F, 8'hF0};
    rd_max_lat = 0;
    rd_words.delete();
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rd_words.push_back(words[i]);
      exp_q.push_back({2'(i), words[i]});
      x ^= words[i];
    end
    rd_words.push_back(x);
    s0 = n_starts;
    w0 = n_writes;
    pulse_load();                 // sampled at edge N
    repeat (4) tick();            // edge N+4: in WAIT of tile 1
    pulse_load();                 // sampled at N+5 while waiting
    repeat (9) tick();            // edge N+14: in DONE
    pulse_load();                 // sampled at N+15 while in DONE
    check("ign_done", done, 1);
    check("ign_busy", busy, 0);
    repeat (4) tick();
    check("ign_still_idle", busy, 0);
    check("ign_start_count", n_starts - s0, 5);
    check("ign_write_count", n_writes - w0, 4);

    // Spurious ready while idle changes nothing.
    w0 = n_writes;
    spurious_req = 1;
    repeat (4) tick();
    check("spur_done", done, 1);
    check("spur_busy", busy, 0);
    check("spur_writes", n_writes - w0, 0);

    // A later load in IDLE clears done and reruns.
    run_load("rerun", x, 5, 1, cyc);

    // Reset during WRITE of tile 2.
    words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rd_max_lat = 0;
    rd_words.delete();
    for (int i = 0; i < 4; i++) rd_words.push_back(words[i]);
    for (int i = 0; i < 3; i++) exp_q.push_back({2'(i), words[i]});
    s0 = n_starts;
    w0 = n_writes;
    pulse_load();                 // edge N
    repeat (8) tick();            // edge N+8: WRITE of tile 2
    check("pre_rst_we", cfg_we, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_fen", fabric_en, 0);
    check("mid_rst_start", reader_start, 0);
    check("mid_rst_we", cfg_we, 0);
    check("mid_rst_addr", cfg_addr, 0);
    check("mid_rst_data", cfg_data, 0);
    rst_n = 1'b1;
    rd_words.delete();
    repeat (5) tick();
    check("post_rst_starts", n_starts - s0, 3);
    check("post_rst_writes", n_writes - w0, 3);
    check("post_rst_pending", exp_q.size(), 0);
    run_load("after_rst", 8'h00 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4, 5, 2, cyc);

    // Randomized loads with random reader latency and random checksums.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++) words[i] = 8'($urandom_range(0, 255));
      x = 8'h00;
      for (int i = 0; i < 4; i++) x ^= words[i];
      if ($urandom_range(1, 0) == 1) x = x ^ 8'($urandom_range(255, 1));
      run_load($sformatf("rand%0d", t), x, 5, 4, cyc);
    end

    // Single-tile instance: word 0xA5, checksum 0xA5.
    load1 = 1'b1;
    tick();
    load1 = 1'b0;
    check("one_busy", busy1, 1);
    one_wait_start("one_start");
    tick();
    rr1 = 1'b1;
    rb1 = 8'hA5;
    tick();
    rr1 = 1'b0;
    check("one_we", we1, 1);
    check("one_addr", addr1, 0);
    check("one_data", data1, 8'hA5);
    one_wait_start("one_chk_start");
    tick();
    rr1 = 1'b1;
    rb1 = 8'hA5;
    tick();
    rr1 = 1'b0;
    cyc = 0;
    while (busy1 && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    check("one_idle", busy1, 0);
    check("one_done", done1, 1);
    check("one_fen", fen1, 1);
    check("one_error", err1, 0);
    check("one_write_count", n_writes1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
